// File: rtl/fb_pkg.sv
// Shared framebuffer geometry defaults, coordinate widths and scheduler state encoding.
package fb_pkg;

  localparam int H_RES_DEF = 640;
  localparam int V_RES_DEF = 480;
  localparam int X_W       = 10;
  localparam int Y_W       = 9;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CLEAR    = 2'd1,
    CLR_DONE = 2'd2
  } fb_state_e;

  // Next round-robin priority after a grant: the requester not just served wins the next tie.
  function automatic logic rr_next(input logic [1:0] grant, input logic rr_cur);
    logic nxt;
    nxt = rr_cur;
    if (grant == 2'b01) nxt = 1'b1;
    if (grant == 2'b10) nxt = 1'b0;
    return nxt;
  endfunction

endpackage

// File: rtl/fb_clear_sweep.sv
// Row-major pixel sweep counter for the full-screen clear; holds on the final pixel.
module fb_clear_sweep
  import fb_pkg::*;
#(
  parameter int H_RES = H_RES_DEF,
  parameter int V_RES = V_RES_DEF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           advance,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic [X_W-1:0] nxt_x,
  output logic [Y_W-1:0] nxt_y,
  output logic           last
);

  localparam logic [X_W-1:0] X_LAST = X_W'(H_RES - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_RES - 1);

  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;

  assign x    = x_q;
  assign y    = y_q;
  assign last = (x_q == X_LAST) && (y_q == Y_LAST);

  // nxt_* is the pixel that follows the current one; it equals the current pixel at the end.
  always_comb begin
    nxt_x = x_q;
    nxt_y = y_q;
    if (!last) begin
      if (x_q == X_LAST) begin
        nxt_x = '0;
        nxt_y = y_q + Y_W'(1);
      end else begin
        nxt_x = x_q + X_W'(1);
      end
    end
  end

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (start) begin
      x_d = '0;
      y_d = '0;
    end else if (advance) begin
      x_d = nxt_x;
      y_d = nxt_y;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

endmodule

// File: rtl/fb_write_sched.sv
// Framebuffer write scheduler: two-requester round-robin draw port plus a full-screen clear sweep.
// Handshake: req[i] is held with its pixel until ack[i]; ack is combinational and one-hot,
// and the acked pixel is presented on the registered fb_* outputs in the following cycle.
module fb_write_sched
  import fb_pkg::*;
#(
  parameter int H_RES = H_RES_DEF,
  parameter int V_RES = V_RES_DEF,
  parameter int CW    = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clear_req,
  input  logic [CW-1:0]  clear_color,
  input  logic [1:0]     req,
  input  logic [X_W-1:0] req0_x,
  input  logic [Y_W-1:0] req0_y,
  input  logic [CW-1:0]  req0_color,
  input  logic [X_W-1:0] req1_x,
  input  logic [Y_W-1:0] req1_y,
  input  logic [CW-1:0]  req1_color,
  output logic [1:0]     ack,
  output logic           fb_we,
  output logic [X_W-1:0] fb_x,
  output logic [Y_W-1:0] fb_y,
  output logic [CW-1:0]  fb_color,
  output logic           busy,
  output logic           clear_done,
  output logic           oob_drop,
  output fb_state_e      state_dbg
);

  localparam logic [X_W-1:0] X_LAST = X_W'(H_RES - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_RES - 1);

  fb_state_e      state_q, state_d;
  logic           rr_q, rr_d;
  logic [CW-1:0]  clr_color_q, clr_color_d;
  logic           fb_we_q, fb_we_d;
  logic [X_W-1:0] fb_x_q, fb_x_d;
  logic [Y_W-1:0] fb_y_q, fb_y_d;
  logic [CW-1:0]  fb_color_q, fb_color_d;
  logic           busy_q, busy_d;
  logic           clear_done_q, clear_done_d;
  logic           oob_q, oob_d;

  logic [1:0]     grant;
  logic [X_W-1:0] sel_x;
  logic [Y_W-1:0] sel_y;
  logic [CW-1:0]  sel_color;
  logic           sel_in_range;
  logic           clr_accept;
  logic           sweep_adv;
  logic [X_W-1:0] sw_x, sw_nxt_x;
  logic [Y_W-1:0] sw_y, sw_nxt_y;
  logic           sw_last;

  assign clr_accept = (state_q == IDLE) && clear_req;
  assign sweep_adv  = (state_q == CLEAR) && !sw_last;

  fb_clear_sweep #(
    .H_RES (H_RES),
    .V_RES (V_RES)
  ) u_sweep (
    .clk     (clk),
    .reset   (reset),
    .start   (clr_accept),
    .advance (sweep_adv),
    .x       (sw_x),
    .y       (sw_y),
    .nxt_x   (sw_nxt_x),
    .nxt_y   (sw_nxt_y),
    .last    (sw_last)
  );

  // rr_q selects the tie winner: 0 favours requester 0, 1 favours requester 1.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = rr_q ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
    ack = 2'b00;
    if ((state_q == IDLE) && !clear_req && !reset) ack = grant;
  end

  always_comb begin
    sel_x     = req0_x;
    sel_y     = req0_y;
    sel_color = req0_color;
    if (ack[1]) begin
      sel_x     = req1_x;
      sel_y     = req1_y;
      sel_color = req1_color;
    end
    sel_in_range = (sel_x <= X_LAST) && (sel_y <= Y_LAST);
  end

  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    clr_color_d  = clr_color_q;
    fb_we_d      = 1'b0;
    fb_x_d       = fb_x_q;
    fb_y_d       = fb_y_q;
    fb_color_d   = fb_color_q;
    busy_d       = 1'b0;
    clear_done_d = 1'b0;
    oob_d        = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear_req) begin
          // The first clear pixel is issued on acceptance so writes track the CLEAR state.
          state_d     = CLEAR;
          clr_color_d = clear_color;
          fb_we_d     = 1'b1;
          fb_x_d      = '0;
          fb_y_d      = '0;
          fb_color_d  = clear_color;
          busy_d      = 1'b1;
        end else if (ack != 2'b00) begin
          rr_d = rr_next(ack, rr_q);
          if (sel_in_range) begin
            fb_we_d    = 1'b1;
            fb_x_d     = sel_x;
            fb_y_d     = sel_y;
            fb_color_d = sel_color;
          end else begin
            oob_d = 1'b1;
          end
        end
      end
      CLEAR: begin
        if (sw_last) begin
          state_d      = CLR_DONE;
          clear_done_d = 1'b1;
        end else begin
          fb_we_d    = 1'b1;
          fb_x_d     = sw_nxt_x;
          fb_y_d     = sw_nxt_y;
          fb_color_d = clr_color_q;
          busy_d     = 1'b1;
        end
      end
      CLR_DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      rr_q         <= 1'b0;
      clr_color_q  <= '0;
      fb_we_q      <= 1'b0;
      fb_x_q       <= '0;
      fb_y_q       <= '0;
      fb_color_q   <= '0;
      busy_q       <= 1'b0;
      clear_done_q <= 1'b0;
      oob_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      clr_color_q  <= clr_color_d;
      fb_we_q      <= fb_we_d;
      fb_x_q       <= fb_x_d;
      fb_y_q       <= fb_y_d;
      fb_color_q   <= fb_color_d;
      busy_q       <= busy_d;
      clear_done_q <= clear_done_d;
      oob_q        <= oob_d;
    end
  end

  assign fb_we      = fb_we_q;
  assign fb_x       = fb_x_q;
  assign fb_y       = fb_y_q;
  assign fb_color   = fb_color_q;
  assign busy       = busy_q;
  assign clear_done = clear_done_q;
  assign oob_drop   = oob_q;
  assign state_dbg  = state_q;

  // The sweep's current pixel is only consumed through nxt_*; keep x/y visible for probing.
  logic unused_sweep;
  assign unused_sweep = ^{sw_x, sw_y};

endmodule

// File: tb/tb_fb_write_sched.sv
// Directed bench for fb_write_sched: reset, arbitration, range drop, clear sweep and reset abort.
module tb_fb_write_sched;
  import fb_pkg::*;

  localparam int H = 640;
  localparam int V = 8;
  localparam int N = H * V;

  logic           clk = 1'b0;
  logic           reset;
  logic           clear_req;
  logic [0:0]     clear_color;
  logic [1:0]     req;
  logic [X_W-1:0] req0_x, req1_x;
  logic [Y_W-1:0] req0_y, req1_y;
  logic [0:0]     req0_color, req1_color;
  logic [1:0]     ack;
  logic           fb_we;
  logic [X_W-1:0] fb_x;
  logic [Y_W-1:0] fb_y;
  logic [0:0]     fb_color;
  logic           busy, clear_done, oob_drop;
  fb_state_e      state_dbg;

  int n_cmp = 0;
  int n_fail = 0;

  fb_write_sched #(.H_RES(H), .V_RES(V), .CW(1)) dut (
    .clk(clk), .reset(reset), .clear_req(clear_req), .clear_color(clear_color),
    .req(req),
    .req0_x(req0_x), .req0_y(req0_y), .req0_color(req0_color),
    .req1_x(req1_x), .req1_y(req1_y), .req1_color(req1_color),
    .ack(ack), .fb_we(fb_we), .fb_x(fb_x), .fb_y(fb_y), .fb_color(fb_color),
    .busy(busy), .clear_done(clear_done), .oob_drop(oob_drop), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // Driver tasks: inputs change only just after a falling edge.
  task automatic drive_req0(input int x, input int y, input logic c);
    req0_x = X_W'(x); req0_y = Y_W'(y); req0_color = c;
  endtask

  task automatic drive_req1(input int x, input int y, input logic c);
    req1_x = X_W'(x); req1_y = Y_W'(y); req1_color = c;
  endtask

  task automatic apply_reset();
    reset = 1'b1; req = 2'b00; clear_req = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Runs one clear from acceptance until the cycle after clear_done, recording what was seen.
  task automatic run_clear(input logic color, input bit second_req,
                           output logic [1:0] accept_ack, output int writes, output int bad,
                           output int dones, output logic [1:0] resume_ack,
                           output int last_x, output int last_y);
    int ex, ey;
    bit done_seen;
    ex = 0; ey = 0; writes = 0; bad = 0; dones = 0; done_seen = 0;
    resume_ack = 2'bxx; last_x = -1; last_y = -1;
    @(negedge clk);
    drive_req0(9, 2, 1'b1);
    req = 2'b01; clear_req = 1'b1; clear_color = color;
    #1 accept_ack = ack;
    for (int i = 0; i < N + 20; i++) begin
      @(negedge clk);
      if (fb_we) begin
        if (fb_x !== X_W'(ex) || fb_y !== Y_W'(ey) || fb_color !== color ||
            busy !== 1'b1 || ack !== 2'b00) bad++;
        last_x = int'(fb_x); last_y = int'(fb_y);
        writes++;
        ex++;
        if (ex == H) begin ex = 0; ey++; end
      end else if (clear_done) begin
        dones++;
        done_seen = 1;
        if (ack !== 2'b00 || busy !== 1'b0) bad++;
      end else if (done_seen) begin
        resume_ack = ack;
        break;
      end
      clear_req = (second_req && writes == 50) ? 1'b1 : 1'b0;
      clear_color = ~color;
    end
    req = 2'b00; clear_req = 1'b0;
    // Any further clear_done would mean a second clear was started.
    repeat (10) begin
      @(negedge clk);
      if (clear_done) dones++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 2'b11; clear_req = 1'b0; clear_color = 1'b0;
    drive_req0(1, 1, 1'b1); drive_req1(2, 2, 1'b1);
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (ack !== 2'b00) begin n_fail++; $display("FAIL reset_ack: got %b exp 00", ack); end
    n_cmp++; if (fb_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b exp 0", fb_we); end
    n_cmp++; if (fb_x !== '0 || fb_y !== '0) begin n_fail++; $display("FAIL reset_xy: got %0d,%0d exp 0,0", fb_x, fb_y); end
    n_cmp++; if (fb_color !== 1'b0) begin n_fail++; $display("FAIL reset_color: got %b exp 0", fb_color); end
    n_cmp++; if ({busy, clear_done, oob_drop} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b exp 000", {busy, clear_done, oob_drop}); end
    n_cmp++; if (state_dbg !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d exp %0d", state_dbg, IDLE); end
    reset = 1'b0; req = 2'b00;
  endtask

  task automatic test_single();
    @(negedge clk);
    drive_req0(5, 7, 1'b1); req = 2'b01;
    #1;
    n_cmp++; if (ack !== 2'b01) begin n_fail++; $display("FAIL single_ack: got %b exp 01", ack); end
    @(negedge clk);
    req = 2'b00;
    n_cmp++; if (fb_we !== 1'b1) begin n_fail++; $display("FAIL single_we: got %b exp 1", fb_we); end
    n_cmp++; if (fb_x !== 10'd5 || fb_y !== 9'd7) begin n_fail++; $display("FAIL single_xy: got %0d,%0d exp 5,7", fb_x, fb_y); end
    n_cmp++; if (fb_color !== 1'b1) begin n_fail++; $display("FAIL single_color: got %b exp 1", fb_color); end
    n_cmp++; if (busy !== 1'b0 || oob_drop !== 1'b0) begin n_fail++; $display("FAIL single_flags: got busy=%b oob=%b exp 0,0", busy, oob_drop); end
    @(negedge clk);
    n_cmp++; if (fb_we !== 1'b0) begin n_fail++; $display("FAIL single_we_off: got %b exp 0", fb_we); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_ack [4];
    exp_ack[0] = 2'b01; exp_ack[1] = 2'b10; exp_ack[2] = 2'b01; exp_ack[3] = 2'b10;
    apply_reset();
    drive_req0(10, 1, 1'b0); drive_req1(20, 2, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i > 0) begin
        n_cmp++;
        if (fb_x !== ((exp_ack[i-1] == 2'b01) ? 10'd10 : 10'd20)) begin
          n_fail++; $display("FAIL rr_data%0d: got x=%0d", i - 1, fb_x);
        end
      end
      req = 2'b11;
      #1;
      n_cmp++; if (ack !== exp_ack[i]) begin n_fail++; $display("FAIL rr_ack%0d: got %b exp %b", i, ack, exp_ack[i]); end
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req = 2'b10;
      #1;
      n_cmp++; if (ack !== 2'b10) begin n_fail++; $display("FAIL lone_ack%0d: got %b exp 10", i, ack); end
    end
    @(negedge clk);
    req = 2'b00;
    n_cmp++; if (fb_we !== 1'b1 || fb_x !== 10'd20 || fb_y !== 9'd2) begin n_fail++; $display("FAIL lone_data: got we=%b %0d,%0d exp 1 20,2", fb_we, fb_x, fb_y); end
  endtask

  task automatic test_oob();
    @(negedge clk);
    drive_req0(640, 0, 1'b1); req = 2'b01;
    #1;
    n_cmp++; if (ack !== 2'b01) begin n_fail++; $display("FAIL oobx_ack: got %b exp 01", ack); end
    @(negedge clk);
    req = 2'b00;
    n_cmp++; if (fb_we !== 1'b0 || oob_drop !== 1'b1) begin n_fail++; $display("FAIL oobx_out: got we=%b oob=%b exp 0,1", fb_we, oob_drop); end
    @(negedge clk);
    n_cmp++; if (oob_drop !== 1'b0) begin n_fail++; $display("FAIL oob_pulse: got %b exp 0", oob_drop); end
    drive_req1(3, V, 1'b1); req = 2'b10;
    #1;
    n_cmp++; if (ack !== 2'b10) begin n_fail++; $display("FAIL ooby_ack: got %b exp 10", ack); end
    @(negedge clk);
    req = 2'b00;
    n_cmp++; if (fb_we !== 1'b0 || oob_drop !== 1'b1) begin n_fail++; $display("FAIL ooby_out: got we=%b oob=%b exp 0,1", fb_we, oob_drop); end
    drive_req1(H - 1, V - 1, 1'b0); req = 2'b10;
    @(negedge clk);
    req = 2'b00;
    n_cmp++; if (fb_we !== 1'b1 || oob_drop !== 1'b0 || fb_x !== 10'(H - 1)) begin n_fail++; $display("FAIL edge_px: got we=%b oob=%b x=%0d exp 1,0,%0d", fb_we, oob_drop, fb_x, H - 1); end
  endtask

  task automatic test_clear(input logic color, input bit second_req, input string tag);
    logic [1:0] accept_ack, resume_ack;
    int writes, bad, dones, last_x, last_y;
    run_clear(color, second_req, accept_ack, writes, bad, dones, resume_ack, last_x, last_y);
    n_cmp++; if (accept_ack !== 2'b00) begin n_fail++; $display("FAIL %s_accept_ack: got %b exp 00", tag, accept_ack); end
    n_cmp++; if (writes != N) begin n_fail++; $display("FAIL %s_writes: got %0d exp %0d", tag, writes, N); end
    n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL %s_pixels: got %0d bad cycles exp 0", tag, bad); end
    n_cmp++; if (last_x != H - 1 || last_y != V - 1) begin n_fail++; $display("FAIL %s_last: got %0d,%0d exp %0d,%0d", tag, last_x, last_y, H - 1, V - 1); end
    n_cmp++; if (dones != 1) begin n_fail++; $display("FAIL %s_done: got %0d pulses exp 1", tag, dones); end
    n_cmp++; if (resume_ack !== 2'b01) begin n_fail++; $display("FAIL %s_resume: got %b exp 01", tag, resume_ack); end
  endtask

  task automatic test_reset_abort();
    bit found;
    int stray;
    found = 0; stray = 0;
    @(negedge clk);
    req = 2'b00; clear_req = 1'b1; clear_color = 1'b1;
    for (int i = 0; i < 3 * H + 200; i++) begin
      @(negedge clk);
      clear_req = 1'b0;
      if (fb_we && fb_x == 10'd100 && fb_y == 9'd3) begin found = 1; break; end
    end
    n_cmp++; if (!found) begin n_fail++; $display("FAIL abort_reach: pixel (100,3) got not seen exp seen"); end
    reset = 1'b1; req = 2'b01;
    @(negedge clk);
    #1;
    n_cmp++; if (fb_we !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL abort_out: got we=%b busy=%b exp 0,0", fb_we, busy); end
    n_cmp++; if (clear_done !== 1'b0 || ack !== 2'b00) begin n_fail++; $display("FAIL abort_done: got done=%b ack=%b exp 0,00", clear_done, ack); end
    reset = 1'b0; req = 2'b00;
    repeat (200) begin
      @(negedge clk);
      if (fb_we || clear_done || busy) stray++;
    end
    n_cmp++; if (stray != 0) begin n_fail++; $display("FAIL abort_quiet: got %0d active cycles exp 0", stray); end
    n_cmp++; if (state_dbg !== IDLE) begin n_fail++; $display("FAIL abort_state: got %0d exp %0d", state_dbg, IDLE); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_oob();
    test_clear(1'b0, 1'b0, "clear");
    test_clear(1'b1, 1'b1, "clear2");
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fb_write_sched.md
FB_WRITE_SCHED -- requirements
Module: fb_write_sched

Interface
REQ-001 SHALL have parameter H_RES, default 640, meaning active pixels per row.
REQ-002 SHALL have parameter V_RES, default 480, meaning active rows.
REQ-003 SHALL have parameter CW, default 1, meaning pixel color width.
REQ-004 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port clear_req  input  1  one-cycle pulse requesting a full-screen clear.
REQ-007 SHALL have port clear_color  input  CW  fill color, sampled in the cycle clear_req is accepted.
REQ-008 SHALL have port req  input  2  draw write request per requester, held until acked.
REQ-009 SHALL have ports req0_x/req1_x  input  10, req0_y/req1_y  input  9, req0_color/req1_color  input  CW  per-requester pixel.
REQ-010 SHALL have port ack  output  2  combinational one-hot grant; requester may change data after an ack cycle.
REQ-011 SHALL have ports fb_we  output  1, fb_x  output  10, fb_y  output  9, fb_color  output  CW  registered framebuffer write.
REQ-012 SHALL have ports busy  output  1  high while clearing, and clear_done  output  1  one-cycle completion pulse.
REQ-013 SHALL have port oob_drop  output  1  one-cycle pulse when an acked write is discarded for range.

Function
REQ-014 SHALL implement FSM states IDLE, CLEAR, CLR_DONE.
REQ-015 IDLE: clear_req high -> CLEAR next cycle; no ack that cycle, even with req pending.
REQ-016 IDLE, no clear_req: if exactly one req bit high, ack it; if both, ack the requester not granted last (round-robin).
REQ-017 Acked pixel SHALL appear on fb_x/fb_y/fb_color with fb_we=1 exactly one cycle after the ack cycle.
REQ-018 Acked pixel with x>=H_RES or y>=V_RES: fb_we stays 0, oob_drop pulses one cycle after ack.
REQ-019 CLEAR: fb_we=1 every cycle, fb_color=latched clear_color, coordinates row-major x 0..H_RES-1 then y+1, from (0,0) to (H_RES-1,V_RES-1).
REQ-020 CLEAR SHALL emit exactly H_RES*V_RES writes (307200 at default) in consecutive cycles; ack=0 throughout.
REQ-021 After last clear write, FSM -> CLR_DONE for one cycle: clear_done=1, fb_we=0, ack=0; then IDLE.
REQ-022 clear_req while in CLEAR or CLR_DONE SHALL be ignored.
REQ-023 busy SHALL be 1 in every cycle fb_we carries a clear write, else 0.
REQ-024 Round-robin pointer SHALL update only on an ack; a lone requester may be acked every cycle.
REQ-025 Sweep counters SHALL be 10-bit x, 9-bit y; no wrap past final pixel.

Reset
REQ-026 On reset: state IDLE, fb_we=0, fb_x=0, fb_y=0, fb_color=0, busy=0, clear_done=0, oob_drop=0, sweep counters 0, round-robin pointer favoring requester 0.
REQ-027 Reset during CLEAR SHALL abort the sweep, with no clear_done pulse and no further writes.
REQ-028 ack SHALL be 0 in any cycle reset is high.

Structure
REQ-029 Package fb_pkg SHALL hold H_RES/V_RES defaults, X_W=10, Y_W=9, and the state enum.
REQ-030 Sweep counter SHALL be sub-module fb_clear_sweep (start, advance, x, y, last).
REQ-031 Arbiter and output register SHALL live in fb_write_sched.

Verification
REQ-032 req=01, (5,7,1) -> ack=01 same cycle; next cycle fb_we=1, fb_x=5, fb_y=7, fb_color=1.
REQ-033 req=11 held 4 cycles after reset -> ack sequence 01,10,01,10.
REQ-034 clear_req with color 0 and req=01 same cycle -> ack=00; 307200 fb_we cycles (0,0)..(639,479); then clear_done one cycle; ack resumes next cycle.
REQ-035 Reset asserted at sweep pixel (100,3) -> next cycle fb_we=0, busy=0, no clear_done.
REQ-036 req0 (640,0) -> ack=01, next cycle fb_we=0, oob_drop=1.
REQ-037 Second clear_req mid-sweep -> write count still exactly 307200, single clear_done.
